// File: rtl/load_store_unit_if.sv
// load_store_unit_if: execute-side request/response handshake
// between the execute stage (master) and the load/store unit (slave).
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid,
    output req_we,
    output req_funct3,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_funct3,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I loads/stores onto a big-endian word memory.
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses.
module load_store_unit #(
  parameter int unsigned DEPTH = 512
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   lsu,
  output logic               mem_en,
  output logic               mem_wen,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MERGE,
    WR,
    RESP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] dat_q;

  logic        accept;
  logic [2:0]  size;
  logic        f3_ok;
  logic [32:0] end_addr;
  logic        range_err;
  logic        misal;
  logic        acc_err;
  logic        is_sw;
  logic [31:0] loaded;
  logic [31:0] merged;

  // Request decode, evaluated only at the accept edge.
  always_comb begin
    size  = 3'd4;
    f3_ok = 1'b1;
    unique case (lsu.req_funct3)
      3'b000: size = 3'd1;
      3'b001: size = 3'd2;
      3'b010: size = 3'd4;
      3'b100: begin
        size  = 3'd1;
        f3_ok = !lsu.req_we;
      end
      3'b101: begin
        size  = 3'd2;
        f3_ok = !lsu.req_we;
      end
      default: f3_ok = 1'b0;
    endcase
  end

  assign end_addr  = {1'b0, lsu.req_addr}
                   + {30'd0, size};
  assign range_err = end_addr > 33'(DEPTH);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misal = ((size == 3'd2) && lsu.req_addr[0])
              || ((size == 3'd4)
                  && (lsu.req_addr[1:0] != 2'b00));
`else
  assign misal = 1'b0;
`endif

  assign acc_err = !f3_ok || range_err || misal;
  assign accept  = lsu.req_valid && (state_q == IDLE);
  assign is_sw   = lsu.req_we
                && (lsu.req_funct3 == 3'b010);

  // Byte at the lowest address sits in bits [31:24].
  always_comb begin
    loaded = mem_rdata;
    unique case (1'b1)
      (f3_q[1:0] == 2'b00):
        loaded = {{24{mem_rdata[31] & ~f3_q[2]}},
                  mem_rdata[31:24]};
      (f3_q[1:0] == 2'b01):
        loaded = {{16{mem_rdata[31] & ~f3_q[2]}},
                  mem_rdata[31:16]};
      default: loaded = mem_rdata;
    endcase
  end

  assign merged = (f3_q[1:0] == 2'b00)
                ? {wdata_q[7:0], mem_rdata[23:0]}
                : {wdata_q[15:0], mem_rdata[15:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    lsu.req_ready   = 1'b0;
    lsu.resp_valid  = 1'b0;
    lsu.resp_rdata  = '0;
    lsu.resp_err    = 1'b0;
    mem_en          = 1'b0;
    mem_wen         = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    unique case (state_q)
      IDLE: begin
        lsu.req_ready = 1'b1;
        if (lsu.req_valid) begin
          unique case (1'b1)
            acc_err: state_d = RESP;
            is_sw:   state_d = WR;
            default: state_d = RD;
          endcase
        end
      end
      RD: begin
        mem_en   = 1'b1;
        mem_addr = addr_q;
        state_d  = MERGE;
      end
      MERGE: begin
        state_d = we_q ? WR : RESP;
      end
      WR: begin
        mem_wen   = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = (f3_q == 3'b010) ? wdata_q
                                     : dat_q;
        state_d   = RESP;
      end
      RESP: begin
        lsu.resp_valid = 1'b1;
        lsu.resp_err   = err_q;
        lsu.resp_rdata = (we_q || err_q) ? '0
                                         : dat_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // dat_q holds the load result or the merged store word.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      if (accept) begin
        we_q    <= lsu.req_we;
        f3_q    <= lsu.req_funct3;
        addr_q  <= lsu.req_addr;
        wdata_q <= lsu.req_wdata;
        err_q   <= acc_err;
        dat_q   <= '0;
      end
      if (state_q == MERGE) begin
        dat_q <= we_q ? merged : loaded;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors against a big-endian
// byte memory model attached to the load/store unit.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int vecs = 0;
  int errs = 0;

  int          lat;
  logic [31:0] r_data;
  logic        r_err;
  int          n_en;
  int          n_wen;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        overlap;
  logic        rdy_resp;

  load_store_unit_if lsu ();

  load_store_unit #(
    .DEPTH (512)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lsu       (lsu),
    .mem_en    (mem_en),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:511];
  logic [31:0] ak;

  function automatic logic [7:0] rb(
    input logic [31:0] a
  );
    if (a < 32'd512) return mem[a[8:0]];
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= {rb(mem_addr),
                    rb(mem_addr + 32'd1),
                    rb(mem_addr + 32'd2),
                    rb(mem_addr + 32'd3)};
    end
    if (mem_wen) begin
      for (int k = 0; k < 4; k++) begin
        ak = mem_addr + 32'(k);
        if (ak < 32'd512)
          mem[ak[8:0]] <= mem_wdata[31-8*k -: 8];
      end
    end
  end

  task automatic do_req(
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] wd
  );
    bit got;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (lsu.req_ready) break;
    end
    lsu.req_valid  = 1'b1;
    lsu.req_we     = we;
    lsu.req_funct3 = f3;
    lsu.req_addr   = a;
    lsu.req_wdata  = wd;
    @(posedge clk);
    #1;
    lsu.req_valid = 1'b0;
    lat = 0; r_data = 'x; r_err = 1'bx;
    n_en = 0; n_wen = 0; overlap = 0;
    w_addr = 'x; w_data = 'x; rdy_resp = 1'bx;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clk);
      if (mem_en) n_en++;
      if (mem_wen) begin
        n_wen++;
        w_addr = mem_addr;
        w_data = mem_wdata;
      end
      if (mem_en && mem_wen) overlap = 1;
      if (lsu.resp_valid) begin
        got = 1;
        lat = i;
        r_data = lsu.resp_rdata;
        r_err = lsu.resp_err;
        rdy_resp = lsu.req_ready;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lsu.req_valid = 1'b0;
    lsu.req_we = 1'b0;
    lsu.req_funct3 = 3'd0;
    lsu.req_addr = '0;
    lsu.req_wdata = '0;
    repeat (3) @(negedge clk);
    vecs++;
    if (lsu.req_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_ready got %b want 1",
               lsu.req_ready);
    end
    vecs++;
    if ({lsu.resp_valid, lsu.resp_err,
         mem_en, mem_wen} !== 4'b0) begin
      errs++;
      $display("FAIL reset_ctl got %b want 0000",
               {lsu.resp_valid, lsu.resp_err,
                mem_en, mem_wen});
    end
    vecs++;
    if ({lsu.resp_rdata, mem_addr, mem_wdata}
        !== 96'd0) begin
      errs++;
      $display("FAIL reset_data got %h %h %h want 0",
               lsu.resp_rdata, mem_addr, mem_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_word();
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    vecs++;
    if (lat !== 2) begin
      errs++;
      $display("FAIL sw_lat got %0d want 2", lat);
    end
    vecs++;
    if (n_wen !== 1 || n_en !== 0) begin
      errs++;
      $display("FAIL sw_pulses got en%0d wen%0d want 0 1",
               n_en, n_wen);
    end
    vecs++;
    if (w_addr !== 32'h10 || w_data !== 32'hDEADBEEF) begin
      errs++;
      $display("FAIL sw_bus got %h %h want 10 deadbeef",
               w_addr, w_data);
    end
    vecs++;
    if (r_err !== 1'b0 || r_data !== 32'h0) begin
      errs++;
      $display("FAIL sw_resp got %b %h want 0 0",
               r_err, r_data);
    end
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    vecs++;
    if (lat !== 3) begin
      errs++;
      $display("FAIL lw_lat got %0d want 3", lat);
    end
    vecs++;
    if (r_data !== 32'hDEADBEEF || r_err !== 1'b0) begin
      errs++;
      $display("FAIL lw_data got %h %b want deadbeef 0",
               r_data, r_err);
    end
    vecs++;
    if (n_en !== 1 || n_wen !== 0 || overlap !== 1'b0) begin
      errs++;
      $display("FAIL lw_pulses got en%0d wen%0d ov%b",
               n_en, n_wen, overlap);
    end
  endtask

  task automatic test_sign_ext();
    logic [2:0]  f3s [4] = '{3'b000, 3'b100,
                             3'b001, 3'b101};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080,
                             32'hFFFF80FF, 32'h000080FF};
    do_req(1'b1, 3'b010, 32'h10, 32'h80FF1234);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, f3s[i], 32'h10, 32'h0);
      vecs++;
      if (r_data !== exp[i] || lat !== 3) begin
        errs++;
        $display("FAIL ext_f3_%b got %h lat%0d want %h lat3",
                 f3s[i], r_data, lat, exp[i]);
      end
    end
  endtask

  task automatic test_rmw();
    do_req(1'b1, 3'b010, 32'h20, 32'h11223344);
    do_req(1'b1, 3'b000, 32'h20, 32'h000000AA);
    vecs++;
    if (lat !== 4) begin
      errs++;
      $display("FAIL sb_lat got %0d want 4", lat);
    end
    vecs++;
    if (w_data !== 32'hAA223344 || w_addr !== 32'h20) begin
      errs++;
      $display("FAIL sb_merge got %h @%h want aa223344 @20",
               w_data, w_addr);
    end
    vecs++;
    if (n_en !== 1 || n_wen !== 1 || overlap !== 1'b0) begin
      errs++;
      $display("FAIL sb_pulses got en%0d wen%0d ov%b",
               n_en, n_wen, overlap);
    end
    do_req(1'b1, 3'b001, 32'h20, 32'h0000BEEF);
    vecs++;
    if (w_data !== 32'hBEEF3344 || lat !== 4) begin
      errs++;
      $display("FAIL sh_merge got %h lat%0d want beef3344 4",
               w_data, lat);
    end
    vecs++;
    if ({mem[32], mem[33], mem[34], mem[35]}
        !== 32'hBEEF3344) begin
      errs++;
      $display("FAIL sh_mem got %h want beef3344",
               {mem[32], mem[33], mem[34], mem[35]});
    end
  endtask

  task automatic test_errors();
    do_req(1'b0, 3'b011, 32'h10, 32'h0);
    vecs++;
    if (r_err !== 1'b1 || r_data !== 32'h0 || lat !== 1) begin
      errs++;
      $display("FAIL f3_err got %b %h lat%0d want 1 0 1",
               r_err, r_data, lat);
    end
    vecs++;
    if (n_en !== 0 || n_wen !== 0) begin
      errs++;
      $display("FAIL f3_err_mem got en%0d wen%0d want 0 0",
               n_en, n_wen);
    end
    do_req(1'b1, 3'b100, 32'h10, 32'h0);
    vecs++;
    if (r_err !== 1'b1 || n_wen !== 0) begin
      errs++;
      $display("FAIL st_f3_err got %b wen%0d want 1 0",
               r_err, n_wen);
    end
    do_req(1'b0, 3'b010, 32'd510, 32'h0);
    vecs++;
    if (r_err !== 1'b1 || lat !== 1 || n_en !== 0) begin
      errs++;
      $display("FAIL range_err got %b lat%0d en%0d",
               r_err, lat, n_en);
    end
    do_req(1'b0, 3'b010, 32'd508, 32'h0);
    vecs++;
    if (r_err !== 1'b0 || lat !== 3) begin
      errs++;
      $display("FAIL range_edge got %b lat%0d want 0 3",
               r_err, lat);
    end
    do_req(1'b0, 3'b000, 32'd511, 32'h0);
    vecs++;
    if (r_err !== 1'b0) begin
      errs++;
      $display("FAIL range_lb511 got %b want 0", r_err);
    end
  endtask

  task automatic test_misalign();
    do_req(1'b1, 3'b010, 32'h14, 32'h55667788);
    do_req(1'b0, 3'b010, 32'h11, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs++;
    if (r_err !== 1'b1 || lat !== 1 || n_en !== 0) begin
      errs++;
      $display("FAIL misal_trap got %b lat%0d en%0d",
               r_err, lat, n_en);
    end
`else
    vecs++;
    if (r_data !== 32'hFF123455 || r_err !== 1'b0
        || lat !== 3) begin
      errs++;
      $display("FAIL misal_lw got %h %b lat%0d want ff123455",
               r_data, r_err, lat);
    end
`endif
  endtask

  task automatic test_back_to_back();
    do_req(1'b0, 3'b010, 32'h20, 32'h0);
    vecs++;
    if (rdy_resp !== 1'b0) begin
      errs++;
      $display("FAIL b2b_busy got %b want 0", rdy_resp);
    end
    @(negedge clk);
    vecs++;
    if (lsu.req_ready !== 1'b1) begin
      errs++;
      $display("FAIL b2b_idle got %b want 1",
               lsu.req_ready);
    end
    do_req(1'b0, 3'b101, 32'h22, 32'h0);
    vecs++;
    if (r_data !== 32'h00003344 || lat !== 3) begin
      errs++;
      $display("FAIL b2b_lhu got %h lat%0d want 3344",
               r_data, lat);
    end
  endtask

  task automatic test_reset_mid();
    int bad_wen;
    int bad_resp;
    bad_wen = 0;
    bad_resp = 0;
    do_req(1'b1, 3'b010, 32'h30, 32'h01020304);
    @(negedge clk);
    lsu.req_valid  = 1'b1;
    lsu.req_we     = 1'b1;
    lsu.req_funct3 = 3'b000;
    lsu.req_addr   = 32'h30;
    lsu.req_wdata  = 32'h000000FF;
    @(posedge clk);
    #1;
    lsu.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    if (mem_wen) bad_wen++;
    if (lsu.resp_valid) bad_resp++;
    rst = 1'b0;
    @(negedge clk);
    vecs++;
    if (lsu.req_ready !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_ready got %b want 1",
               lsu.req_ready);
    end
    for (int i = 0; i < 6; i++) begin
      if (mem_wen) bad_wen++;
      if (lsu.resp_valid) bad_resp++;
      @(negedge clk);
    end
    vecs++;
    if (bad_wen !== 0 || bad_resp !== 0) begin
      errs++;
      $display("FAIL rstmid_quiet got wen%0d resp%0d want 0",
               bad_wen, bad_resp);
    end
    vecs++;
    if ({mem[48], mem[49], mem[50], mem[51]}
        !== 32'h01020304) begin
      errs++;
      $display("FAIL rstmid_mem got %h want 01020304",
               {mem[48], mem[49], mem[50], mem[51]});
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_sign_ext();
    test_rmw();
    test_errors();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

- Sits between the execute stage and `data_memory`; it is the requesting side of the data-memory port.
- Accepts one load or store per transaction and drives `data_memory`'s `en`/`wen`/`addr`/`data_i` pins.
- Loads: extracts and sign- or zero-extends byte, halfword or word results.
- Sub-word stores: done as read-modify-write, because the memory only writes whole 4-byte big-endian groups (byte at `addr` is bits [31:24]).

## Interface
- `DEPTH`, 512, byte depth of the attached `data_memory`; used for the range check.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle; request accepted when `req_valid && req_ready` at a rising edge.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3 (load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the low bits are used for SB/SH.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load result, valid with `resp_valid`; 0 for stores and errors.
- `resp_err`  out  1  illegal funct3, out-of-range or misaligned access; valid with `resp_valid`.
- `mem_en`  out  1  read enable to memory.
- `mem_wen`  out  1  write enable to memory.
- `mem_addr`  out  32  byte address to memory.
- `mem_wdata`  out  32  write data to memory.
- `mem_rdata`  in  32  memory read data, registered, valid the cycle after `mem_en`.

## Operation
- States: IDLE, RD, MERGE, WR, RESP.
- IDLE:
  - `req_ready`=1.
  - On accept, latch `req_we`, `req_funct3`, `req_addr`, `req_wdata`.
  - Access size is 1/2/4 bytes.
- Error check at accept. Next state is RESP with `resp_err`=1 and no memory access when any of:
  - funct3 is illegal;
  - `req_addr + size > DEPTH`;
  - misaligned (see Configuration).
- Next state at accept:
  - load: RD.
  - SW: WR.
  - SB/SH: RD.
- RD: `mem_en`=1, `mem_addr`=latched address → MERGE.
- MERGE: `mem_rdata` is valid in this cycle.
  - Load: format into a result register → RESP.
    - LB: `mem_rdata[31:24]` sign-extended.
    - LBU: `mem_rdata[31:24]` zero-extended.
    - LH: `mem_rdata[31:16]` sign-extended.
    - LHU: `mem_rdata[31:16]` zero-extended.
    - LW: full word.
  - Store: build the merged word into a register → WR.
    - SB: {`wdata[7:0]`, `mem_rdata[23:0]`}.
    - SH: {`wdata[15:0]`, `mem_rdata[15:0]`}.
- WR:
  - `mem_wen`=1, `mem_addr`=latched address.
  - `mem_wdata`= merged word, or the latched wdata for SW.
  - `mem_en`=0 → RESP.
- RESP: `resp_valid`=1 for one cycle → IDLE. There is no response backpressure.
- `mem_en` and `mem_wen` are never high in the same cycle.
- Memory-side outputs are 0 in every state except RD and WR.

## Timing
- Reset values: state IDLE, `req_ready`=1; `resp_valid`, `resp_err`, `mem_en`, `mem_wen` = 0; `resp_rdata`, `mem_addr`, `mem_wdata` = 0.
- Latency counts cycles from the accept edge to the cycle in which `resp_valid` is high:
  - load: 3;
  - SW: 2;
  - SB/SH: 4;
  - error: 1.
- Throughput: `req_ready` is low from the cycle after accept through RESP, and high again the cycle after RESP. A new request is therefore accepted no sooner than the edge that ends the first IDLE cycle after RESP.
- `rst` in any state: IDLE at the next edge, with all outputs at their reset values.
  - A `rst` asserted during the WR cycle does not cancel that write; memory samples `mem_wen` at the same edge.
  - A pending response is dropped.
- `mem_rdata` is sampled only in MERGE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: these accesses complete as errors, with no memory access and latency 1:
  - LH/LHU/SH with `addr[0]`=1;
  - LW/SW with `addr[1:0]`≠0.
- Not defined: misaligned addresses are legal and handled by the byte-addressed memory exactly like aligned ones; only illegal funct3 and range errors report `resp_err`.

## Test plan
- Word round trip: SW addr 0x10, wdata 0xDEADBEEF → `mem_wen` pulse with addr 0x10, data 0xDEADBEEF; `resp_valid` 2 cycles after accept. Then LW 0x10 → `resp_rdata`=0xDEADBEEF, 3 cycles after accept.
- Sign extension: memory bytes 0x10..0x13 = 80 FF 12 34 →
  - LB 0x10 = 0xFFFFFF80;
  - LBU 0x10 = 0x00000080;
  - LH 0x10 = 0xFFFF80FF;
  - LHU 0x10 = 0x000080FF.
- Read-modify-write: word 0x11223344 at 0x20, SB 0x20 wdata 0x000000AA → sequence RD, MERGE, WR with `mem_wdata`=0xAA223344; `resp_valid` 4 cycles after accept. SH 0x20 wdata 0x0000BEEF → 0xBEEF3344.
- Errors:
  - funct3 011 load → `resp_err`=1, `resp_rdata`=0, no `mem_en`/`mem_wen`.
  - LW addr 510 with DEPTH 512 → `resp_err`=1.
  - With `LSU_MISALIGN_TRAP_EN`: LW addr 0x11 → `resp_err`=1. Without it: normal data from 0x11.
- Reset mid-operation: assert `rst` in the MERGE cycle of an SB → no `mem_wen` afterwards, `resp_valid` never pulses, `req_ready`=1 the cycle after reset deasserts, and the memory word is unchanged.
